pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: width of each data channel.
REQ-002 The block SHALL have parameter NUM_CH, default 4: number of data channels (alu result, B, updated PC, next PC).
REQ-003 The block SHALL have parameter CTRL_W, default 8: width of the control-bit vector (RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump, Branching, Jump, branchingPCEnable).
REQ-004 The block SHALL have parameter WREG_W, default 3: width of the destination-register index.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream stage holds a valid instruction.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept an instruction this cycle.
REQ-009 The block SHALL have port in_data, input, NUM_CH*DATA_W bits: channel k at bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W bits: control vector.
REQ-011 The block SHALL have port in_wreg, input, WREG_W bits: destination register index.
REQ-012 The block SHALL have port flush, input, 1 bit: squash all held instructions.
REQ-013 The block SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head entry.
REQ-015 The block SHALL have ports out_data (NUM_CH*DATA_W), out_ctrl (CTRL_W), out_wreg (WREG_W), all outputs: head entry fields.
REQ-016 The block SHALL have port occupancy, output, 2 bits: entries held (0..2).

Function
REQ-017 The block SHALL hold up to two entries, head and skid, each storing data, ctrl, wreg and a valid bit; order SHALL be FIFO.
REQ-018 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; consume SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be a registered signal equal to 1 exactly when the skid entry is empty; it SHALL NOT combinationally depend on out_ready.
REQ-020 Latency SHALL be one cycle: an instruction accepted into an empty block SHALL appear on the outputs with out_valid=1 on the following cycle.
REQ-021 Occupancy 0, accept: SHALL load head; occupancy becomes 1.
REQ-022 Occupancy 1, accept and consume together: SHALL load head with the new entry; occupancy stays 1.
REQ-023 Occupancy 1, accept without consume: SHALL load skid; occupancy becomes 2; in_ready becomes 0.
REQ-024 Occupancy 2, consume: SHALL move skid to head; occupancy becomes 1; in_ready becomes 1.
REQ-025 Occupancy 1, consume only: SHALL leave occupancy at 0.
REQ-026 When no accept and no consume occur, all stored fields SHALL remain unchanged (stall hold).
REQ-027 out_ctrl SHALL be all zeros whenever out_valid=0, so a bubble is a NOP with no RegWrite or DMemWrite side effect; out_data and out_wreg are don't-care then.
REQ-028 flush=1 at a rising edge SHALL clear both valid bits and both ctrl fields, set occupancy to 0 and in_ready to 1; an accept or consume in that same cycle SHALL be discarded.
REQ-029 Flush SHALL take priority over accept and consume.
REQ-030 occupancy SHALL equal the number of set valid bits, never exceed 2, and never underflow.

Reset
REQ-031 While rst=0, the block SHALL asynchronously clear both valid bits, ctrl, data and wreg fields to zero and drive out_valid=0, out_ctrl=0, out_data=0, out_wreg=0, occupancy=0, in_ready=1.
REQ-032 The block SHALL accept its first instruction at the first rising edge after rst returns to 1; reset mid-transfer SHALL lose all held entries.

Verification
REQ-033 Basic flow: rst release, in_valid=1, in_data ch0=16'h1234, in_ctrl=8'h81, in_wreg=3'd5, out_ready=1 -> next cycle out_valid=1, out_data ch0=16'h1234, out_ctrl=8'h81, out_wreg=5, occupancy=1.
REQ-034 Backpressure: out_ready=0, push A then B -> occupancy=2, in_ready=0, C held upstream; set out_ready=1 -> outputs A, B, C in order over three cycles, no loss or duplication.
REQ-035 Full throughput: in_valid=1 and out_ready=1 for 10 cycles with data 0..9 -> out_valid=1 on cycles 1..10 with data 0..9, occupancy constant at 1.
REQ-036 Flush: occupancy=2 with in_valid=1, pulse flush -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1, flushed-cycle input absent.
REQ-037 Async reset: assert rst=0 mid-cycle with occupancy=2 -> outputs zero and in_ready=1 immediately without a clock edge.
REQ-038 Parameter sweep: NUM_CH=1, DATA_W=32, CTRL_W=4 with random valid/ready/flush traffic -> output sequence matches a scoreboard model.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: two-entry (head + skid) pipeline register with a registered in_ready,
// one-cycle latency, flush, and bubbles that present an all-zero (NOP) control vector.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 8,
  parameter int WREG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [WREG_W-1:0]        in_wreg,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [WREG_W-1:0]        out_wreg,
  output logic [1:0]               occupancy
);

  localparam int PAY_W = NUM_CH * DATA_W;

  logic              head_valid;
  logic [PAY_W-1:0]  head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic [WREG_W-1:0] head_wreg;

  logic              skid_valid;
  logic [PAY_W-1:0]  skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [WREG_W-1:0] skid_wreg;

  logic              ready_q;
  logic              accept;
  logic              consume;

  assign accept  = in_valid & ready_q;
  assign consume = head_valid & out_ready;

  // ready_q tracks "skid empty" as a flop, so upstream never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_ctrl  <= '0;
      head_wreg  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_wreg  <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      head_valid <= 1'b0;
      head_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      ready_q    <= 1'b1;
    end else if (skid_valid) begin
      // Full: ready_q is low, so only a consume can happen here.
      if (consume) begin
        head_data  <= skid_data;
        head_ctrl  <= skid_ctrl;
        head_wreg  <= skid_wreg;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
        ready_q    <= 1'b1;
      end
    end else if (head_valid) begin
      if (accept && consume) begin
        head_data <= in_data;
        head_ctrl <= in_ctrl;
        head_wreg <= in_wreg;
      end else if (accept) begin
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
        skid_wreg  <= in_wreg;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end else if (consume) begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      head_data  <= in_data;
      head_ctrl  <= in_ctrl;
      head_wreg  <= in_wreg;
      head_valid <= 1'b1;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_wreg  = head_wreg;
  assign out_ctrl  = head_valid ? head_ctrl : '0;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

  a_skid_implies_head : assert property (@(posedge clk) disable iff (!rst)
    skid_valid |-> head_valid);
  a_ready_is_skid_empty : assert property (@(posedge clk) disable iff (!rst)
    ready_q == !skid_valid);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Self-checking bench: two configurations against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_stage_reg;

  localparam int WW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;

  logic [63:0] in_data0 = '0;
  logic [7:0]  in_ctrl0 = '0;
  logic [2:0]  in_wreg0 = '0;
  logic [31:0] in_data1 = '0;
  logic [3:0]  in_ctrl1 = '0;
  logic [2:0]  in_wreg1 = '0;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [63:0] out_data0;
  logic [7:0]  out_ctrl0;
  logic [2:0]  out_wreg0;
  logic [1:0]  occ0;
  logic [31:0] out_data1;
  logic [3:0]  out_ctrl1;
  logic [2:0]  out_wreg1;
  logic [1:0]  occ1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [2:0]  w;
  } item_t;

  item_t mq[2][$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .NUM_CH(4), .CTRL_W(8), .WREG_W(WW)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .in_wreg(in_wreg0), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .out_wreg(out_wreg0), .occupancy(occ0)
  );

  pipe_stage_reg #(.DATA_W(32), .NUM_CH(1), .CTRL_W(4), .WREG_W(WW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data1), .in_ctrl(in_ctrl1), .in_wreg(in_wreg1), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .out_wreg(out_wreg1), .occupancy(occ1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity two; ready means "fewer than two held at cycle start".
  always @(posedge clk or negedge rst) begin
    item_t it;
    bit acc, con;
    if (!rst) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          mq[k].delete();
        end else begin
          acc = in_valid && (mq[k].size() < 2);
          con = out_ready && (mq[k].size() > 0);
          if (con) void'(mq[k].pop_front());
          if (acc) begin
            if (k == 0) begin
              it.d = in_data0; it.c = in_ctrl0; it.w = in_wreg0;
            end else begin
              it.d = {32'h0, in_data1}; it.c = {4'h0, in_ctrl1}; it.w = in_wreg1;
            end
            mq[k].push_back(it);
          end
        end
      end
    end
  end

  task automatic cmp(input int k, input logic v, input logic [63:0] d, input logic [7:0] c,
                     input logic [2:0] w, input logic [1:0] occ, input logic rdy);
    int n;
    n = mq[k].size();
    chk($sformatf("dut%0d.out_valid", k), 64'(v), 64'(n > 0));
    chk($sformatf("dut%0d.occupancy", k), 64'(occ), 64'(n));
    chk($sformatf("dut%0d.in_ready", k), 64'(rdy), 64'(n < 2));
    chk($sformatf("dut%0d.out_ctrl", k), 64'(c), (n > 0) ? 64'(mq[k][0].c) : 64'h0);
    if (n > 0) begin
      chk($sformatf("dut%0d.out_data", k), d, mq[k][0].d);
      chk($sformatf("dut%0d.out_wreg", k), 64'(w), 64'(mq[k][0].w));
    end else if (!rst) begin
      chk($sformatf("dut%0d.out_data_rst", k), d, 64'h0);
      chk($sformatf("dut%0d.out_wreg_rst", k), 64'(w), 64'h0);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, out_valid0, out_data0, out_ctrl0, out_wreg0, occ0, in_ready0);
    cmp(1, out_valid1, {32'h0, out_data1}, {4'h0, out_ctrl1}, out_wreg1, occ1, in_ready1);
  end

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [63:0] d, input logic [7:0] c, input logic [2:0] w);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_data0  = d;
    in_ctrl0  = c;
    in_wreg0  = w;
    in_data1  = $urandom;
    in_ctrl1  = 4'($urandom);
    in_wreg1  = 3'($urandom);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.in_ready", 64'(in_ready0), 64'h1);
    chk("reset.out_data", out_data0, 64'h0);

    // Basic flow right after reset release
    rst = 1'b1;
    drive(1, 1, 0, 64'hAAAA_BBBB_CCCC_1234, 8'h81, 3'd5);
    @(negedge clk);
    chk("basic.out_valid", 64'(out_valid0), 64'h1);
    chk("basic.ch0", 64'(out_data0[15:0]), 64'h1234);
    chk("basic.out_ctrl", 64'(out_ctrl0), 64'h81);
    chk("basic.out_wreg", 64'(out_wreg0), 64'd5);
    chk("basic.occ", 64'(occ0), 64'd1);
    drive(0, 1, 0, 64'h0, 8'h0, 3'd0);
    @(negedge clk);
    chk("basic.drained", 64'(occ0), 64'd0);

    // Backpressure: A, B held, C waits upstream
    drive(1, 0, 0, 64'hA, 8'h1A, 3'd1);
    @(negedge clk);
    drive(1, 0, 0, 64'hB, 8'h1B, 3'd2);
    @(negedge clk);
    chk("bp.occ_full", 64'(occ0), 64'd2);
    chk("bp.in_ready_low", 64'(in_ready0), 64'h0);
    chk("bp.model_full", 64'(mq[0].size()), 64'd2);
    chk("bp.head_A", out_data0, 64'hA);
    drive(1, 1, 0, 64'hC, 8'h1C, 3'd3);
    @(negedge clk);
    chk("bp.head_B", out_data0, 64'hB);
    @(negedge clk);
    chk("bp.head_C", out_data0, 64'hC);
    chk("bp.ctrl_C", 64'(out_ctrl0), 64'h1C);
    drive(0, 1, 0, 64'h0, 8'h0, 3'd0);
    @(negedge clk);
    chk("bp.empty", 64'(occ0), 64'd0);
    chk("bp.bubble_ctrl", 64'(out_ctrl0), 64'h0);

    // Full throughput: 0..9 streamed with occupancy held at 1
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 64'(i), 8'h80, 3'(i));
      @(negedge clk);
      chk("thru.data", out_data0, 64'(i));
      chk("thru.occ", 64'(occ0), 64'd1);
    end
    drive(0, 1, 0, 64'h0, 8'h0, 3'd0);
    @(negedge clk);

    // Flush with two held and an input offered in the flush cycle
    drive(1, 0, 0, 64'h11, 8'hF1, 3'd1);
    @(negedge clk);
    drive(1, 0, 0, 64'h22, 8'hF2, 3'd2);
    @(negedge clk);
    drive(1, 1, 1, 64'h33, 8'hF3, 3'd3);
    @(negedge clk);
    chk("flush.occ", 64'(occ0), 64'd0);
    chk("flush.valid", 64'(out_valid0), 64'h0);
    chk("flush.ctrl", 64'(out_ctrl0), 64'h0);
    chk("flush.in_ready", 64'(in_ready0), 64'h1);
    drive(0, 1, 0, 64'h0, 8'h0, 3'd0);
    @(negedge clk);
    chk("flush.input_absent", 64'(occ0), 64'd0);

    // Asynchronous reset mid-cycle with two held
    drive(1, 0, 0, 64'h44, 8'hE4, 3'd4);
    @(negedge clk);
    drive(1, 0, 0, 64'h55, 8'hE5, 3'd5);
    @(negedge clk);
    chk("arst.pre_occ", 64'(occ0), 64'd2);
    drive(0, 0, 0, 64'h0, 8'h0, 3'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid0), 64'h0);
    chk("arst.ctrl", 64'(out_ctrl0), 64'h0);
    chk("arst.data", out_data0, 64'h0);
    chk("arst.wreg", 64'(out_wreg0), 64'h0);
    chk("arst.occ", 64'(occ0), 64'd0);
    chk("arst.in_ready", 64'(in_ready0), 64'h1);
    chk("arst.occ1", 64'(occ1), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Random traffic on both configurations
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
            {$urandom, $urandom}, 8'($urandom), 3'($urandom));
      @(negedge clk);
    end
    drive(0, 0, 0, 64'h0, 8'h0, 3'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
